// File: rtl/prog_loader.sv
// UART (8N1) boot loader: receives a little-endian word count, then that many words, into instruction memory.
// Defining PROG_LOADER_CHKSUM_EN adds a trailing XOR checksum byte that must match before the CPU is released.
`timescale 1ns/1ps
module prog_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int WORD         = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic        cpu_rst,
  output logic        busy,
  output logic        done,
  output logic        err
);
  localparam int            CW        = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [31:0]   WORD_MAX  = 32'(WORD);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {L_LEN, L_DATA, L_DONE, L_ERR} ld_state_t;

  logic          rx_meta_r, rx_sync_r, rx_prev_r;
  rx_state_t     rx_state_r;
  logic [CW-1:0] clk_cnt_r;
  logic [2:0]    bit_cnt_r;
  logic [7:0]    shift_r;
  logic [7:0]    byte_r;
  logic          byte_valid_r, frame_err_r;

  ld_state_t     ld_state_r;
  logic [1:0]    byte_cnt_r;
  logic [31:0]   asm_r, len_r, idx_r;
  logic [31:0]   mem_addr_r, mem_wdata_r;
  logic          mem_we_r, cpu_rst_r, busy_r, done_r, err_r;
  logic [31:0]   word_next_s;

`ifdef PROG_LOADER_CHKSUM_EN
  logic [7:0] chk_r;
  logic       chk_wait_r;

  function automatic logic [7:0] chk_next(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction
`endif

  // Incoming bytes fill from the top so the first byte ends up in bits [7:0].
  assign word_next_s = {byte_r, asm_r[31:8]};

  // Two-flop synchronizer plus a delayed copy for falling-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
    end
  end

  // UART receiver: mid-bit sampling, one-cycle byte_valid / frame_err pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state_r   <= RX_IDLE;
      clk_cnt_r    <= CNT_ZERO;
      bit_cnt_r    <= 3'd0;
      shift_r      <= 8'd0;
      byte_r       <= 8'd0;
      byte_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
    end else begin
      byte_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
      case (rx_state_r)
        RX_IDLE: begin
          clk_cnt_r <= CNT_ZERO;
          bit_cnt_r <= 3'd0;
          if (rx_prev_r && !rx_sync_r) rx_state_r <= RX_START;
          else                         rx_state_r <= RX_IDLE;
        end
        RX_START: begin
          if (clk_cnt_r == HALF_LAST) begin
            clk_cnt_r  <= CNT_ZERO;
            rx_state_r <= rx_sync_r ? RX_IDLE : RX_DATA;
          end else begin
            clk_cnt_r <= clk_cnt_r + CNT_ONE;
          end
        end
        RX_DATA: begin
          if (clk_cnt_r == BIT_LAST) begin
            clk_cnt_r <= CNT_ZERO;
            shift_r   <= {rx_sync_r, shift_r[7:1]};
            bit_cnt_r <= bit_cnt_r + 3'd1;
            if (bit_cnt_r == 3'd7) rx_state_r <= RX_STOP;
            else                   rx_state_r <= RX_DATA;
          end else begin
            clk_cnt_r <= clk_cnt_r + CNT_ONE;
          end
        end
        RX_STOP: begin
          if (clk_cnt_r == BIT_LAST) begin
            clk_cnt_r  <= CNT_ZERO;
            rx_state_r <= RX_IDLE;
            if (rx_sync_r) begin
              byte_valid_r <= 1'b1;
              byte_r       <= shift_r;
            end else begin
              frame_err_r <= 1'b1;
            end
          end else begin
            clk_cnt_r <= clk_cnt_r + CNT_ONE;
          end
        end
        default: rx_state_r <= RX_IDLE;
      endcase
    end
  end

  // Loader: length and word assembly, memory writes, status flags derived from the settled state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ld_state_r  <= L_LEN;
      byte_cnt_r  <= 2'd0;
      asm_r       <= 32'd0;
      len_r       <= 32'd0;
      idx_r       <= 32'd0;
      mem_addr_r  <= 32'd0;
      mem_wdata_r <= 32'd0;
      mem_we_r    <= 1'b0;
      cpu_rst_r   <= 1'b1;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
`ifdef PROG_LOADER_CHKSUM_EN
      chk_r       <= 8'd0;
      chk_wait_r  <= 1'b0;
`endif
    end else begin
      mem_we_r  <= 1'b0;
      cpu_rst_r <= (ld_state_r != L_DONE);
      done_r    <= (ld_state_r == L_DONE);
      err_r     <= (ld_state_r == L_ERR);
      if (ld_state_r == L_DONE || ld_state_r == L_ERR) busy_r <= 1'b0;
      else if (byte_valid_r)                           busy_r <= 1'b1;
      else                                             busy_r <= busy_r;

      case (ld_state_r)
        L_LEN: begin
          if (frame_err_r) begin
            ld_state_r <= L_ERR;
          end else if (byte_valid_r) begin
            asm_r      <= word_next_s;
            byte_cnt_r <= byte_cnt_r + 2'd1;
`ifdef PROG_LOADER_CHKSUM_EN
            chk_r      <= chk_next(chk_r, byte_r);
`endif
            if (byte_cnt_r == 2'd3) begin
              len_r <= word_next_s;
              if (word_next_s > WORD_MAX) begin
                ld_state_r <= L_ERR;
              end else if (word_next_s == 32'd0) begin
`ifdef PROG_LOADER_CHKSUM_EN
                ld_state_r <= L_DATA;
                chk_wait_r <= 1'b1;
`else
                ld_state_r <= L_DONE;
`endif
              end else begin
                ld_state_r <= L_DATA;
              end
            end
          end
        end
        L_DATA: begin
          if (frame_err_r) begin
            ld_state_r <= L_ERR;
          end else if (byte_valid_r) begin
`ifdef PROG_LOADER_CHKSUM_EN
            if (chk_wait_r) begin
              ld_state_r <= (byte_r == chk_r) ? L_DONE : L_ERR;
            end else begin
              chk_r <= chk_next(chk_r, byte_r);
`endif
              asm_r      <= word_next_s;
              byte_cnt_r <= byte_cnt_r + 2'd1;
              if (byte_cnt_r == 2'd3) begin
                mem_we_r    <= 1'b1;
                mem_addr_r  <= idx_r;
                mem_wdata_r <= word_next_s;
                idx_r       <= idx_r + 32'd1;
                if (idx_r == len_r - 32'd1) begin
`ifdef PROG_LOADER_CHKSUM_EN
                  chk_wait_r <= 1'b1;
`else
                  ld_state_r <= L_DONE;
`endif
                end
              end
`ifdef PROG_LOADER_CHKSUM_EN
            end
`endif
          end
        end
        L_DONE:  ld_state_r <= L_DONE;
        L_ERR:   ld_state_r <= L_ERR;
        default: ld_state_r <= L_ERR;
      endcase
    end
  end

  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign mem_we    = mem_we_r;
  assign cpu_rst   = cpu_rst_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign err       = err_r;
endmodule

// File: tb/tb_prog_loader.sv
// Randomized bench for prog_loader: UART byte streams checked every cycle against a stream-level model.
`timescale 1ns/1ps
module tb_prog_loader;
  localparam int CPB   = 16;
  localparam int WORDS = 8;
  localparam int AW    = $clog2(WORDS);

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rx  = 1'b1;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_we, cpu_rst, busy, done, err;

  prog_loader #(.CLKS_PER_BIT(CPB), .WORD(WORDS)) dut (
    .clk(clk), .rst(rst), .rx(rx),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .cpu_rst(cpu_rst), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef logic [7:0] bq_t[$];

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic        exp_done = 1'b0, exp_err = 1'b0, exp_fall_we = 1'b0;
  logic [31:0] last_addr = 32'd0, last_data = 32'd0;
  logic        prev_cpu_rst = 1'b1, prev_we = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Stream-level model: expected writes and final outcome from the byte list and the bad-stop index.
  task automatic model(input bq_t s, input int bad);
    logic [31:0] n;
    int          base;
    logic [7:0]  x;
    exp_addr_q.delete();
    exp_data_q.delete();
    exp_done = 1'b0; exp_err = 1'b0; exp_fall_we = 1'b0;
    if (bad >= 0 && bad < 4) begin exp_err = 1'b1; return; end
    n = {s[3], s[2], s[1], s[0]};
    if (n > WORDS) begin exp_err = 1'b1; return; end
    for (int k = 0; k < int'(n); k++) begin
      base = 4 + 4 * k;
      if (bad >= base && bad < base + 4) begin exp_err = 1'b1; return; end
      exp_addr_q.push_back(32'(k));
      exp_data_q.push_back({s[base+3], s[base+2], s[base+1], s[base]});
    end
    base = 4 + 4 * int'(n);
    x = 8'd0;
`ifdef PROG_LOADER_CHKSUM_EN
    if (bad == base) begin exp_err = 1'b1; return; end
    for (int i = 0; i < base; i++) x = x ^ s[i];
    if (s[base] == x) exp_done = 1'b1;
    else              exp_err  = 1'b1;
`else
    exp_done    = 1'b1;
    exp_fall_we = (n != 32'd0) && (x == 8'd0);
`endif
  endtask

  function automatic bq_t make_stream(input logic [31:0] n, input logic [31:0] words[$], input int extra);
    bq_t        s;
    logic [7:0] x;
    for (int b = 0; b < 4; b++) s.push_back(n[8*b +: 8]);
    foreach (words[k]) for (int b = 0; b < 4; b++) s.push_back(words[k][8*b +: 8]);
    x = 8'd0;
    foreach (s[i]) x = x ^ s[i];
`ifdef PROG_LOADER_CHKSUM_EN
    s.push_back(x);
`endif
    repeat (extra) s.push_back(8'($urandom_range(0, 255)));
    return s;
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic bad_stop);
    rx = 1'b0; wait_cycles(CPB);
    for (int i = 0; i < 8; i++) begin rx = b[i]; wait_cycles(CPB); end
    rx = ~bad_stop; wait_cycles(CPB);
    rx = 1'b1; wait_cycles($urandom_range(2, 10));
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b0; rx = 1'b1;
    wait_cycles(3);
    rst = 1'b1;
  endtask

  task automatic run_load(input string tag, input bq_t s, input int bad);
    int t;
    do_reset();
    model(s, bad);
    for (int i = 0; i < s.size(); i++) begin
      send_byte(s[i], i == bad);
      if (i == 0 && bad != 0) check({tag, "_busy_after_first_byte"}, busy, 1);
    end
    t = 0;
    while (!(done || err) && t < 200) begin wait_cycles(1); t++; end
    wait_cycles(4);
    check({tag, "_done"}, done, exp_done);
    check({tag, "_err"}, err, exp_err);
    check({tag, "_busy_end"}, busy, 0);
    check({tag, "_cpu_rst_end"}, cpu_rst, !exp_done);
    check({tag, "_missing_writes"}, exp_addr_q.size(), 0);
  endtask

  // Per-cycle compare of DUT outputs against the model's write queue and the status invariants.
  always @(negedge clk) begin
    if (!rst) begin
      check("reset_state", {mem_we, cpu_rst, busy, done, err, (mem_addr | mem_wdata) != 32'd0},
            {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
      last_addr    <= 32'd0;
      last_data    <= 32'd0;
      prev_cpu_rst <= 1'b1;
      prev_we      <= 1'b0;
    end else begin
      if (mem_we) begin
        check("write_expected", exp_addr_q.size() > 0, 1);
        if (exp_addr_q.size() > 0) begin
          check("write_addr", mem_addr, exp_addr_q[0]);
          check("write_data", mem_wdata, exp_data_q[0]);
          last_addr <= exp_addr_q[0];
          last_data <= exp_data_q[0];
          void'(exp_addr_q.pop_front());
          void'(exp_data_q.pop_front());
        end
      end else begin
        check("hold_addr_data", {mem_addr, mem_wdata}, {last_addr, last_data});
      end
      check("addr_upper_zero", mem_addr >> AW, 0);
      check("cpu_rst_vs_done", cpu_rst, !done);
      check("done_err_exclusive", done & err, 0);
      if (prev_cpu_rst && !cpu_rst) check("cpu_rst_fall_after_write", prev_we, exp_fall_we);
      prev_cpu_rst <= cpu_rst;
      prev_we      <= mem_we;
    end
  end

  initial begin
    #900000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bq_t         s;
    logic [31:0] wq[$];
    logic [31:0] n;
    int          bad;

    // Basic two-word load, model pinned to hand-computed values first.
    wq = '{32'h12345678, 32'hDEADBEEF};
    s  = make_stream(32'd2, wq, 0);
    model(s, -1);
    check("pin_nwrites", exp_addr_q.size(), 2);
    check("pin_w0_data", exp_data_q[0], 32'h12345678);
    check("pin_w1_addr", exp_addr_q[1], 32'd1);
    check("pin_w1_data", exp_data_q[1], 32'hDEADBEEF);
    run_load("basic", s, -1);

    // Empty program.
    wq.delete();
    run_load("len_zero", make_stream(32'd0, wq, 0), -1);

    // Oversized length: 4097 and WORDS+1.
    s = make_stream(32'h0000_1001, wq, 0);
    model(s, -1);
    check("pin_ovf_err", exp_err, 1);
    check("pin_ovf_nwrites", exp_addr_q.size(), 0);
    run_load("len_4097", s, -1);
    run_load("len_word_plus1", make_stream(32'(WORDS + 1), wq, 0), -1);

    // Exactly WORDS words fills memory to the last index.
    for (int k = 0; k < WORDS; k++) wq.push_back($urandom());
    run_load("len_word_max", make_stream(32'(WORDS), wq, 1), -1);

    // Framing error on the third data byte; later bytes ignored.
    wq = '{32'hA5A5_0001, 32'h5A5A_0002};
    run_load("frame_err", make_stream(32'd2, wq, 2), 6);

`ifdef PROG_LOADER_CHKSUM_EN
    wq = '{32'h0000_00AA};
    s  = make_stream(32'd1, wq, 0);
    check("pin_chksum_byte", s[8], 8'hAB);
    run_load("chksum_good", s, -1);
    s[8] = 8'h00;
    run_load("chksum_bad", s, -1);
`endif

    // Reset in the middle of word 0, then the full stream again.
    wq = '{32'h12345678, 32'hDEADBEEF};
    s  = make_stream(32'd2, wq, 0);
    do_reset();
    exp_addr_q.delete(); exp_data_q.delete();
    exp_fall_we = 1'b0;
    for (int i = 0; i < 6; i++) send_byte(s[i], 1'b0);
    check("partial_no_done", done | err, 0);
    run_load("restart", s, -1);

    // Randomized loads with optional bad stop bit and trailing junk.
    for (int it = 0; it < 6; it++) begin
      n = 32'($urandom_range(1, 4));
      wq.delete();
      for (int k = 0; k < int'(n); k++) wq.push_back($urandom());
      s   = make_stream(n, wq, $urandom_range(0, 2));
      bad = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, s.size() - 1)) : -1;
      run_load($sformatf("rand%0d", it), s, bad);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, clock cycles per UART bit (100 MHz / 115200 baud).
REQ-002 Parameter WORD, default 4096, capacity of the target instruction memory in 32-bit words.
REQ-003 Port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 Port rst  input  1  asynchronous, active-low reset.
REQ-005 Port rx  input  1  UART serial data: 8N1, LSB first, idle high, asynchronous to clk.
REQ-006 Port mem_addr  output  32  word address for the instruction-memory write port.
REQ-007 Port mem_wdata  output  32  word to write.
REQ-008 Port mem_we  output  1  write strobe, one cycle per word.
REQ-009 Port cpu_rst  output  1  active-high reset to the processor; held while loading.
REQ-010 Port busy  output  1  high from first received byte until load finishes.
REQ-011 Port done  output  1  sticky; load completed successfully.
REQ-012 Port err  output  1  sticky; framing, overflow or checksum error.

Function
REQ-013 rx SHALL pass a 2-flop synchronizer before any use; added latency 2 cycles.
REQ-014 UART receiver states SHALL be RX_IDLE, RX_START, RX_DATA, RX_STOP.
  - RX_IDLE -> RX_START on synchronized falling edge.
  - RX_START: sample at CLKS_PER_BIT/2; low -> RX_DATA, high -> RX_IDLE (glitch, no error).
  - RX_DATA: sample every CLKS_PER_BIT, 8 bits, LSB first.
  - RX_STOP: sample once; high -> byte valid for 1 cycle, low -> framing error, byte discarded; both -> RX_IDLE.
REQ-015 Loader states SHALL be L_LEN, L_DATA, L_DONE, L_ERR.
REQ-016 L_LEN: assemble 4 bytes little-endian into 32-bit count N; after 4th byte -> L_DATA, or -> L_DONE directly if N==0.
REQ-017 L_DATA: assemble 4 bytes little-endian per word; on 4th byte assert mem_we for exactly 1 cycle with mem_addr = word index (0,1,2,...) and mem_wdata = assembled word; index increments after the write.
REQ-018 After word N-1 is written -> L_DONE; done=1, busy=0, cpu_rst deasserts the following cycle.
REQ-019 N > WORD SHALL -> L_ERR at the 4th length byte; no writes occur.
REQ-020 Any framing error SHALL -> L_ERR immediately; writes already issued stand.
REQ-021 L_ERR: err=1, busy=0, cpu_rst held 1, mem_we 0; exit only by reset.
REQ-022 L_DONE: further rx bytes SHALL be received and ignored; no writes, flags unchanged.
REQ-023 cpu_rst SHALL be 1 in every state except L_DONE.
REQ-024 mem_addr[31:log2(WORD)] SHALL always be 0; the index never wraps.
REQ-025 mem_addr and mem_wdata SHALL hold their last values when mem_we=0.

Reset
REQ-026 While rst=0: mem_addr=0, mem_wdata=0, mem_we=0, cpu_rst=1, busy=0, done=0, err=0, loader in L_LEN, receiver in RX_IDLE, byte and word counters 0.
REQ-027 Reset asserted mid-byte or mid-word SHALL discard all partial data; a new load restarts at length byte 0.

Configuration
REQ-028 With PROG_LOADER_CHKSUM_EN defined: after the last data word (or after the length when N==0) one extra byte is expected, the XOR of all preceding bytes, length bytes included; match -> L_DONE, mismatch -> L_ERR; all data writes are still issued before the check.
REQ-029 Without PROG_LOADER_CHKSUM_EN: no checksum byte; L_DONE is entered directly after the last word; no checksum logic is synthesized.

Verification
REQ-030 CLKS_PER_BIT=16, chksum off; bytes 02 00 00 00, 78 56 34 12, EF BE AD DE -> writes (0,0x12345678), (1,0xDEADBEEF); done=1; cpu_rst falls 1 cycle after the 2nd write.
REQ-031 Length 00 00 00 00 -> no mem_we; done=1, cpu_rst=0.
REQ-032 Length 01 10 00 00 (N=4097) with WORD=4096 -> err=1, no mem_we, cpu_rst stays 1.
REQ-033 Stop bit driven low on the 3rd data byte -> err=1, no write for that word, later bytes ignored.
REQ-034 Chksum on; N=1, word 0x000000AA, checksum byte 0xAB -> write issued, done=1; same stimulus with checksum 0x00 -> err=1, cpu_rst stays 1.
REQ-035 rst pulsed low after 2 bytes of word 0, then full valid stream resent -> writes start at address 0 with correct data; done=1.
